// File: rtl/aes_decipher_block_p_if.sv
// Handshake and data bundle between the AES core control, the round-key supplier
// and the iterative inverse-cipher datapath.
interface aes_decipher_block_p_if;
  logic         next;
  logic [1:0]   keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         key_valid;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, round_key, key_valid, block,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, round_key, key_valid, block,
    output round, new_block, ready
  );
endinterface

// File: rtl/aes_decipher_block_p.sv
// Iterative AES inverse cipher: one round key per INIT/MAIN step, with the inverse
// S-box applied to SBOX_LANES 32-bit words per cycle in between.
module aes_decipher_block_p #(
  parameter int SBOX_LANES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  aes_decipher_block_p_if.slave  bus
);

  generate
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
      $error("aes_decipher_block_p: SBOX_LANES must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t         state;
  logic [3:0]     round_r;
  logic [127:0]   blk_r;
  logic           ready_r;
  logic [1:0]     wctr;
  logic [1:0]     keylen_r;
  logic [127:0]   sbox_next;

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      2'd0:    return 4'd10;
      2'd1:    return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_sb(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sb(w[31:24]), inv_sb(w[23:16]), inv_sb(w[15:8]), inv_sb(w[7:0])};
  endfunction

  // Circulant {0e,0b,0d,09} built from repeated doubling of each input byte.
  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31 - 8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] sub_lanes(input logic [127:0] s, input logic [1:0] ctr);
    logic [127:0] o;
    int           w;
    o = s;
    for (int i = 0; i < SBOX_LANES; i++) begin
      w = (int'(ctr) + i) % 4;
      o[127 - 32*w -: 32] = inv_sub_word(s[127 - 32*w -: 32]);
    end
    return o;
  endfunction

  always_comb begin
    sbox_next = sub_lanes(blk_r, wctr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      round_r  <= 4'd0;
      blk_r    <= '0;
      ready_r  <= 1'b1;
      wctr     <= 2'd0;
      keylen_r <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.next) begin
            keylen_r <= bus.keylen;
            round_r  <= nr_of(bus.keylen);
            ready_r  <= 1'b0;
            state    <= INIT;
          end
        end
        INIT: begin
          if (bus.key_valid) begin
            blk_r   <= inv_shift_rows(bus.block ^ bus.round_key);
            round_r <= nr_of(keylen_r) - 4'd1;
            wctr    <= 2'd0;
            state   <= SBOX;
          end
        end
        SBOX: begin
          blk_r <= sbox_next;
          wctr  <= wctr + 2'(SBOX_LANES);
          if (({1'b0, wctr} + 3'(SBOX_LANES)) == 3'd4) begin
            state <= MAIN;
          end
        end
        MAIN: begin
          if (!bus.key_valid) begin
            wctr <= 2'd0;
          end else if (round_r != 4'd0) begin
            blk_r   <= inv_shift_rows(inv_mix_columns(blk_r ^ bus.round_key));
            round_r <= round_r - 4'd1;
            wctr    <= 2'd0;
            state   <= SBOX;
          end else begin
            blk_r   <= blk_r ^ bus.round_key;
            ready_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.round     = round_r;
  assign bus.new_block = blk_r;
  assign bus.ready     = ready_r;

endmodule
